// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with burst lock up to MAX_BURST beats.
// Optional macro ARB_HIPRI0_EN: requester 0 wins whenever no lock is being honoured.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DWIDTH-1:0]    req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DWIDTH-1:0]         fifo_din,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      locked
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_locked;

    logic          w_sel_vld;
    logic [OW-1:0] w_sel;
    logic          w_acc;
    logic          w_keep;
    logic [CW-1:0] w_cnt_n;
    logic [OW-1:0] w_ptr_nxt;
    int unsigned   w_idx;

    // Selection: honour an active lock, else search round-robin from r_ptr.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = '0;
        w_idx     = 0;
        if (!fifo_full) begin
            if (r_locked && req[r_owner]) begin
                w_sel_vld = 1'b1;
                w_sel     = r_owner;
            end
`ifdef ARB_HIPRI0_EN
            else if (req[0]) begin
                w_sel_vld = 1'b1;
                w_sel     = '0;
            end
`endif
            else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    w_idx = (32'(r_ptr) + k) % NREQ;
                    if (!w_sel_vld && req[w_idx]) begin
                        w_sel_vld = 1'b1;
                        w_sel     = OW'(w_idx);
                    end
                end
            end
        end
    end

    // Outputs are gated by rst so no beat is accepted while reset is held.
    assign w_acc     = w_sel_vld && !rst;
    assign w_keep    = r_locked && (w_sel == r_owner);
    assign w_cnt_n   = w_keep ? (r_cnt + CW'(1)) : CW'(1);
    assign w_ptr_nxt = (w_sel == OW'(NREQ - 1)) ? '0 : (w_sel + OW'(1));

    always_comb begin
        ack      = '0;
        fifo_din = '0;
        if (w_acc) begin
            ack[w_sel] = 1'b1;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_acc && (w_sel == OW'(i))) begin
                fifo_din = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign fifo_wr_en = w_acc;
    assign owner      = r_owner;
    assign locked     = r_locked;

    // Burst/lock state; a stalled FIFO holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else if (w_acc) begin
            if (!w_keep) begin
                r_owner <= w_sel;
            end
            r_ptr <= w_ptr_nxt;
            if (w_cnt_n == CW'(MAX_BURST)) begin
                r_locked <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_locked <= 1'b1;
                r_cnt    <= w_cnt_n;
            end
        end else if (!fifo_full && r_locked && !req[r_owner]) begin
            r_locked <= 1'b0;
            r_cnt    <= '0;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of a FIFO (wr_en/data_in/full) between NREQ independent producers.
- Round-robin arbitration with bounded burst lock: a granted producer keeps the port for up to MAX_BURST consecutive accepted beats, then must yield.
- Sits directly in front of the FIFO write side. The FIFO's full flag is the only backpressure source.

Parameters:
NREQ, 4, number of requesters (2..16)
DWIDTH, 8, data width, matches FIFO dwidth
MAX_BURST, 4, max consecutive beats per grant (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset
req  input  NREQ  per-requester valid; bit i = requester i
req_data  input  NREQ*DWIDTH  flattened data; slice i = [i*DWIDTH +: DWIDTH]
ack  output  NREQ  one-hot beat-accepted strobe to requesters
fifo_full  input  1  FIFO full flag
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  DWIDTH  FIFO write data
owner  output  clog2(NREQ)  index of last/current granted requester (status)
locked  output  1  burst lock active (status)

Behaviour:
- Reset: asynchronous, active-high; reset rst, clock clk. On reset: locked=0, owner=0, burst count cnt=0, round-robin pointer ptr=0.
- Handshake: requester i asserts req[i] with stable req_data slice until it sees ack[i]=1 at a rising edge. Each ack is one beat.
- ack, fifo_wr_en and fifo_din are combinational from req, fifo_full and state. Zero-latency: beat accepted in the same cycle the FIFO writes it.
- Selection sel (combinational, only when fifo_full=0):
  - If locked=1 and req[owner]=1: sel=owner.
  - Otherwise: first i with req[i]=1, searching ptr, ptr+1, ..., wrapping mod NREQ.
  - No request: no sel.
- Beat accepted when sel exists and fifo_full=0:
  - ack[sel]=1, fifo_wr_en=1, fifo_din=slice sel.
  - Otherwise: ack=0, fifo_wr_en=0, fifo_din=0.
- fifo_full=1: no ack, no write; all state holds; lock preserved across the stall.
- State update on accepted beat:
  - If locked=1 and sel==owner: cnt_n=cnt+1; else cnt_n=1 and owner<=sel.
  - If cnt_n==MAX_BURST: locked<=0, cnt<=0, ptr<=(sel+1) mod NREQ.
  - Else: locked<=1, cnt<=cnt_n, ptr<=(sel+1) mod NREQ.
- Lock release on drop: if locked=1 and req[owner]=0 with fifo_full=0, locked<=0, cnt<=0 that cycle. The same cycle's selection already uses the RR search from ptr (=owner+1), so another requester can be acked in that cycle.
- MAX_BURST=1: locked never asserts; pure per-beat round-robin.
- NREQ not a power of two: the ptr increment wraps explicitly at NREQ.
- Reset mid-burst: lock and pointer are cleared. Any ack in that cycle is suppressed because outputs are gated by rst.

Optional Feature:
- Macro: ARB_HIPRI0_EN.
- Defined: when locked=0, req[0]=1 wins selection regardless of ptr. An existing lock is never pre-empted. Requester 0 bursts obey MAX_BURST, and ptr updates to 1 after them.
- Undefined: pure round-robin as above.

Test Plan:
- Single requester: req=0001, data 0xA0..0xA7, fifo_full=0 -> 8 consecutive acks to req 0; locked toggles 1,1,1,0 every 4 beats; FIFO receives A0..A7 in order.
- All four request continuously, full=0 -> grant order 0×4, 1×4, 2×4, 3×4, 0×4; exactly one ack per cycle.
- Req 1 locked after 2 beats, then drops req[1] while req[3]=1 -> ack[3] in that same cycle, owner=3, cnt=1.
- fifo_full held 3 cycles mid-burst (cnt=2) -> no ack or wr_en for 3 cycles; after release the same owner finishes 2 more beats, then rotates.
- rst pulsed mid-burst with req=1111 -> ack=0 during reset; first post-reset grant goes to requester 0.
- ARB_HIPRI0_EN defined, req[2] bursting, req[0] raised -> req 2 completes its 4 beats, then req 0 granted before req 3.
